// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// buffers one word across stalls, and drives the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PC_write,
  input  logic               IF_ID_write,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [ADDR_W-1:0]  IF_ID_pc_plus4,
  output logic               IF_ID_valid
);

  typedef enum logic [1:0] {ST_REQ, ST_HOLD, ST_DROP} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic               stall;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               unused_tgt_bits;

  assign stall           = ~PC_write | ~IF_ID_write;
  assign pc_plus4        = pc_q + ADDR_W'(4);
  assign redirect_pc     = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_d       = buf_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;

    imem_req  = (state_q != ST_HOLD) & ~reset;
    imem_addr = (state_q == ST_DROP) ? drop_addr_q : {pc_q[ADDR_W-1:2], 2'b00};

    if (branch_taken) begin
      // Redirect wins over stall; an unacked in-flight request must still drain.
      pc_d    = redirect_pc;
      instr_d = '0;
      valid_d = 1'b0;
      buf_d   = '0;
      state_d = ST_REQ;
      if (state_q == ST_REQ && !imem_ack) begin
        state_d     = ST_DROP;
        drop_addr_d = pc_q;
      end else if (state_q == ST_DROP && !imem_ack) begin
        state_d = ST_DROP;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (stall) begin
            if (imem_ack) begin
              buf_d   = imem_rdata;
              state_d = ST_HOLD;
            end
          end else if (imem_ack) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            instr_d = '0;
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_d = buf_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      buf_q       <= '0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_q       <= buf_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign IF_ID_instr    = instr_q;
  assign IF_ID_pc_plus4 = pc4_q;
  assign IF_ID_valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed + randomized bench for if_fetch_stage against a cycle-level
// behavioural model with a variable-latency instruction memory.
module tb_if_fetch_stage;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam logic [AW-1:0] RPC = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, PC_write = 1'b1, IF_ID_write = 1'b1, branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] IF_ID_instr;
  logic [AW-1:0] IF_ID_pc_plus4;
  logic          IF_ID_valid;

  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [IW-1:0] w_instr;
  logic [AW-1:0] w_pc4;
  logic          w_valid;

  if_fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IF_ID_instr(IF_ID_instr),
    .IF_ID_pc_plus4(IF_ID_pc_plus4), .IF_ID_valid(IF_ID_valid)
  );

  // Second instance exercises PC wraparound with a zero-latency memory.
  if_fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req),
    .imem_rdata(w_addr + 32'h1000), .IF_ID_instr(w_instr),
    .IF_ID_pc_plus4(w_pc4), .IF_ID_valid(w_valid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [AW-1:0] m_pc = RPC, m_drain_addr = '0, m_pc4 = '0;
  logic [IW-1:0] m_instr = '0, m_buf = '0;
  logic          m_holding = 1'b0, m_draining = 1'b0, m_valid = 1'b0, m_known = 1'b0;

  // Memory model
  logic          mem_busy = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  int            mem_lat = 0;
  int            lat_mode = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic pw, input logic iw,
                       input logic br, input logic [AW-1:0] tgt);
    logic stall;
    stall = !pw || !iw;
    @(negedge clk);
    reset = rst; PC_write = pw; IF_ID_write = iw; branch_taken = br; branch_target = tgt;
    #1;
    if (m_known || rst) chk1("imem_req", imem_req, !rst && !m_holding);
    if (imem_req) begin
      chk32("imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end else begin
        chk32("addr_stable", imem_addr, mem_addr);
      end
      imem_ack   = (mem_lat == 0);
      imem_rdata = imem_ack ? imem_addr + 32'h1000 : $urandom;
    end else begin
      mem_busy   = 1'b0;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    if (m_known) begin
      chk32("IF_ID_instr", IF_ID_instr, m_instr);
      chk32("IF_ID_pc_plus4", IF_ID_pc_plus4, m_pc4);
      chk1("IF_ID_valid", IF_ID_valid, m_valid);
    end
    @(posedge clk);
    if (rst) begin
      m_pc = RPC; m_holding = 0; m_draining = 0;
      m_instr = '0; m_pc4 = '0; m_valid = 0; m_known = 1;
    end else if (br) begin
      if (m_draining) m_draining = !imem_ack;
      else if (!m_holding && !imem_ack) begin
        m_draining = 1; m_drain_addr = m_pc;
      end
      m_holding = 0;
      m_pc = {tgt[AW-1:2], 2'b00};
      m_instr = '0; m_valid = 0;
    end else if (m_draining) begin
      if (imem_ack) m_draining = 0;
    end else if (m_holding) begin
      if (!stall) begin
        m_instr = m_buf; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_holding = 0;
      end
    end else if (imem_ack) begin
      if (stall) begin
        m_buf = imem_rdata; m_holding = 1;
      end else begin
        m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end
    end else if (!stall) begin
      m_instr = '0; m_valid = 0;
    end
    if (imem_req) begin
      if (imem_ack) mem_busy = 1'b0;
      else mem_lat--;
    end
  endtask

  initial begin
    // Reset, then zero-latency memory
    lat_mode = 0;
    cycle(1, 1, 1, 0, '0);
    cycle(1, 1, 1, 0, '0);
    #2;
    chk1("reset_valid", IF_ID_valid, 1'b0);
    chk32("reset_instr", IF_ID_instr, 32'h0);
    chk32("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("seq0_instr", IF_ID_instr, 32'h1000);
    chk32("seq0_pc4", IF_ID_pc_plus4, 32'h4);
    chk1("seq0_valid", IF_ID_valid, 1'b1);
    chk32("wrap_pc4", w_pc4, 32'h0);
    chk32("wrap_instr", w_instr, 32'h0000_0FFC);
    chk1("wrap_valid", w_valid, 1'b1);
    chk32("wrap_second_addr", w_addr, 32'h0);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("seq1_instr", IF_ID_instr, 32'h1004);
    chk32("seq1_pc4", IF_ID_pc_plus4, 32'h8);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("seq2_instr", IF_ID_instr, 32'h1008);
    chk32("seq2_pc4", IF_ID_pc_plus4, 32'hC);

    // Three-cycle ack latency: two bubbles
    lat_mode = 2;
    cycle(0, 1, 1, 0, '0);
    #2;
    chk1("lat_bubble_valid", IF_ID_valid, 1'b0);
    chk32("lat_bubble_instr", IF_ID_instr, 32'h0);
    chk32("lat_bubble_pc4", IF_ID_pc_plus4, 32'hC);
    cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("lat_instr", IF_ID_instr, 32'h100C);
    chk32("lat_pc4", IF_ID_pc_plus4, 32'h10);

    // Stall with ack in the first stall cycle
    lat_mode = 0;
    cycle(0, 0, 0, 0, '0);
    #2;
    chk32("stall_hold_instr", IF_ID_instr, 32'h100C);
    cycle(0, 0, 0, 0, '0);
    #2;
    chk1("hold_req_low", imem_req, 1'b0);
    chk32("hold_instr", IF_ID_instr, 32'h100C);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("release_instr", IF_ID_instr, 32'h1010);
    chk32("release_pc4", IF_ID_pc_plus4, 32'h14);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("after_release_instr", IF_ID_instr, 32'h1014);

    // Branch while a request at 0x10 is outstanding
    cycle(0, 1, 1, 1, 32'h10);
    lat_mode = 3;
    cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 1, 32'h203);
    #2;
    chk1("br_bubble_valid", IF_ID_valid, 1'b0);
    chk32("drop_addr", imem_addr, 32'h10);
    lat_mode = 0;
    cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk1("drop_no_write", IF_ID_valid, 1'b0);
    chk32("redirect_addr", imem_addr, 32'h200);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("redirect_instr", IF_ID_instr, 32'h1200);
    chk32("redirect_pc4", IF_ID_pc_plus4, 32'h204);

    // Branch during HOLD with stall still asserted
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, 32'h300);
    #2;
    chk1("hold_br_valid", IF_ID_valid, 1'b0);
    chk32("hold_br_addr", imem_addr, 32'h300);
    chk1("hold_br_req", imem_req, 1'b1);
    cycle(0, 1, 1, 0, '0);
    #2;
    chk32("hold_br_instr", IF_ID_instr, 32'h1300);
    chk32("hold_br_pc4", IF_ID_pc_plus4, 32'h304);

    // Randomized traffic
    lat_mode = -1;
    for (int n = 0; n < 3000; n++) begin
      logic r, p, w, b;
      logic [AW-1:0] t;
      r = ($urandom_range(0, 63) == 0);
      p = ($urandom_range(0, 4) != 0);
      w = ($urandom_range(0, 4) != 0);
      b = ($urandom_range(0, 9) == 0);
      t = $urandom;
      cycle(r, p, w, b, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage with the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and consumes that unit's PC_write / IF_ID_write stall controls. It owns the PC, issues requests to instruction memory over a req/ack handshake of variable latency, and buffers one fetched word while the pipeline is stalled. It squashes IF/ID on a taken branch.

Parameters:
ADDR_W, 32, PC and instruction-memory address width
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
PC_write  input  1  1 = PC may advance; 0 = stall (from hazard unit)
IF_ID_write  input  1  1 = IF/ID may load; 0 = hold (from hazard unit)
branch_taken  input  1  single-cycle redirect pulse
branch_target  input  ADDR_W  redirect address; bits [1:0] ignored
imem_req  output  1  fetch request
imem_addr  output  ADDR_W  fetch address, {pc[ADDR_W-1:2],2'b00}
imem_ack  input  1  response valid; meaningful only while imem_req=1
imem_rdata  input  INSTR_W  instruction word, valid with imem_ack
IF_ID_instr  output  INSTR_W  registered instruction; 0 (NOP) when bubble
IF_ID_pc_plus4  output  ADDR_W  registered fetch address + 4
IF_ID_valid  output  1  registered: IF/ID holds a real instruction

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset. On reset: pc=RESET_PC, state=REQ, IF_ID_instr=0, IF_ID_pc_plus4=0, IF_ID_valid=0, hold buffer empty. imem_req goes low in the reset cycle and is high from the first cycle after.
- stall = ~PC_write | ~IF_ID_write. A mismatch between the two is treated as a stall.
- States: REQ, HOLD, DROP.
  - imem_req=1 in REQ and DROP; 0 in HOLD.
  - imem_addr = pc in REQ; the old in-flight address in DROP.
  - Address must stay stable while req=1 until ack.
- Priority each cycle: reset > branch_taken > stall > normal.
- REQ, ack=1, no branch, no stall:
  - IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay REQ.
  - Best-case throughput is one instruction per cycle with zero-latency ack.
- REQ, ack=0, no branch, no stall: IF/ID <= bubble (instr=0, valid=0, pc_plus4 unchanged); pc holds.
- REQ, ack=1, stall: imem_rdata captured into hold buffer; go HOLD; pc and IF/ID hold.
- REQ, ack=0, stall: pc and IF/ID hold; request stays up.
- HOLD, stall: everything holds.
- HOLD, no stall: IF/ID <= {buffer, pc+4, 1}; pc <= pc+4; go REQ.
- branch_taken (any state):
  - pc <= {branch_target[ADDR_W-1:2],2'b00}; IF/ID <= bubble; hold buffer discarded.
  - If REQ with ack=0, go DROP, because the in-flight request must complete. Otherwise go REQ. Any same-cycle rdata is discarded.
- DROP: req held at the old address until ack. Data is discarded and IF/ID is not written; next state is REQ at the redirected pc. A second branch_taken in DROP updates pc only and stays in DROP.
- Stall is ignored for redirect: branch_taken always redirects and bubbles IF/ID.
- pc arithmetic is modulo 2^ADDR_W: pc 0xFFFFFFFC advances to 0x00000000, and IF_ID_pc_plus4 wraps the same way.
- Reset mid-transaction: the outstanding request is abandoned; the memory model must tolerate req dropping.

Test Plan:
- Reset, then ack every cycle with rdata=0x1000+addr -> IF_ID_valid=1 from cycle 2; instructions 0x1000, 0x1004, 0x1008 with pc_plus4 = 4, 8, 0xC.
- Ack latency 3 cycles -> two bubble cycles (valid=0, instr=0) between instructions; imem_addr stable while req=1.
- PC_write=IF_ID_write=0 for 2 cycles, ack arriving in the first stall cycle -> state HOLD, req=0, IF/ID unchanged. The buffered word appears in IF/ID the cycle the stall lifts, with no duplicate and no loss.
- branch_taken, target=0x203 (pulsed while a request at 0x10 is outstanding) -> IF/ID bubble; 0x10 data discarded in DROP; next request address 0x200.
- branch_taken during HOLD with stall still asserted -> buffer dropped, IF/ID bubble, next fetch at target.
- RESET_PC=0xFFFFFFFC -> first instruction pc_plus4=0x0; second fetch address 0x0.
